sd_cmd_rx: RTL and testbench

Host-to-card command receiver for the SD device emulator. It oversamples the SD bus clock and CMD line in the system `clk` domain and deserializes 48-bit host command frames. Each frame is checked for start, transmission and end bits and CRC7, and is handed to the command responder as a one-cycle `cmd_valid` strobe with the decoded index and argument. It sits between the `sd_clk_i`/`sd_cmd_i` pads and the command-decode/response stage.

---
 rtl/sd_cmd_rx.sv | 181 ++++++++++++++++++
 tb/tb_sd_cmd_rx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_rx.sv
// rtl/sd_cmd_rx.sv - SD host-to-card command frame receiver
//
// Oversamples the SD bus clock and CMD line in the clk domain, deserializes
// 48-bit host command frames, checks start/transmission/end bits and CRC7,
// and emits one-cycle result strobes.
//
// Ports:
//   clk        system clock, at least 4x sd_clk_i
//   reset      synchronous active-high reset
//   sd_clk_i   SD bus clock pad (asynchronous)
//   sd_cmd_i   SD CMD line pad (idle high)
//   rx_enable  receive enable; low forces IDLE and discards partial frames
//   busy       high while a frame is being received
//   cmd_valid  one-cycle strobe: good frame received
//   cmd_index  command index of the last good frame
//   cmd_arg    argument of the last good frame
//   crc_err    one-cycle strobe: frame complete with CRC7 mismatch
//   frame_err  one-cycle strobe: frame complete, CRC good, end bit 0

module sd_cmd_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sd_clk_i,
    input  logic        sd_cmd_i,
    input  logic        rx_enable,
    output logic        busy,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        crc_err,
    output logic        frame_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RX   = 1'b1
    } state_t;

    localparam int MSB = SYNC_STAGES - 1;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] cmd_sync_q, cmd_sync_d;
    logic                   clk_prev_q, clk_prev_d;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [6:0]  crc_q, crc_d;
    logic        crc_bad_q, crc_bad_d;
    logic [39:0] frame_q, frame_d;

    logic        cmd_valid_q, cmd_valid_d;
    logic        crc_err_q, crc_err_d;
    logic        frame_err_q, frame_err_d;
    logic [5:0]  cmd_index_q, cmd_index_d;
    logic [31:0] cmd_arg_q, cmd_arg_d;

    logic        sample;
    logic        bit_in;
    logic        crc_fb;
    logic [6:0]  crc_next;
    logic        hdr_ok;

    always_comb begin
        // Both synchronizer chains have identical depth so the sampled CMD
        // bit is the one present at the sd_clk rising edge.
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], sd_clk_i};
        cmd_sync_d = {cmd_sync_q[SYNC_STAGES-2:0], sd_cmd_i};
        clk_prev_d = clk_sync_q[MSB];

        sample = clk_sync_q[MSB] & ~clk_prev_q;
        bit_in = cmd_sync_q[MSB];

        // CRC7, polynomial x^7 + x^3 + 1, MSB first.
        crc_fb   = crc_q[6] ^ bit_in;
        crc_next = {crc_q[5:0], 1'b0} ^ {3'b000, crc_fb, 2'b00, crc_fb};

        // Start and transmission bits sit at the top of the frame register.
        hdr_ok = ~frame_q[39] & frame_q[38];

        state_d     = state_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        crc_bad_d   = crc_bad_q;
        frame_d     = frame_q;
        cmd_index_d = cmd_index_q;
        cmd_arg_d   = cmd_arg_q;
        cmd_valid_d = 1'b0;
        crc_err_d   = 1'b0;
        frame_err_d = 1'b0;

        if (!rx_enable) begin
            state_d = ST_IDLE;
        end else if (sample) begin
            case (state_q)
                ST_IDLE: begin
                    if (!bit_in) begin
                        // The start bit (bit 47) is consumed here. Shifting a
                        // 0 into a cleared CRC leaves it 0, so the CRC is
                        // simply cleared; the counter then points at bit 46.
                        state_d   = ST_RX;
                        cnt_d     = 6'd46;
                        crc_d     = 7'd0;
                        crc_bad_d = 1'b0;
                        frame_d   = 40'd0;
                    end
                end
                ST_RX: begin
                    cnt_d = cnt_q - 6'd1;
                    if (cnt_q >= 6'd8) begin
                        frame_d = {frame_q[38:0], bit_in};
                        crc_d   = crc_next;
                        // Transmission bit 0 means a card response on the
                        // shared line: drop it silently.
                        if (cnt_q == 6'd46 && !bit_in) begin
                            state_d = ST_IDLE;
                        end
                    end else if (cnt_q != 6'd0) begin
                        // Bit n (7..1) carries CRC bit n-1.
                        if (bit_in != crc_q[3'(cnt_q - 6'd1)]) begin
                            crc_bad_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        if (crc_bad_q) begin
                            crc_err_d = 1'b1;
                        end else if (!bit_in) begin
                            frame_err_d = 1'b1;
                        end else if (hdr_ok) begin
                            cmd_valid_d = 1'b1;
                            cmd_index_d = frame_q[37:32];
                            cmd_arg_d   = frame_q[31:0];
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= '1;
            cmd_sync_q  <= '1;
            clk_prev_q  <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= 6'd0;
            crc_q       <= 7'd0;
            crc_bad_q   <= 1'b0;
            frame_q     <= 40'd0;
            cmd_valid_q <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            cmd_index_q <= 6'd0;
            cmd_arg_q   <= 32'd0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            cmd_sync_q  <= cmd_sync_d;
            clk_prev_q  <= clk_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            crc_bad_q   <= crc_bad_d;
            frame_q     <= frame_d;
            cmd_valid_q <= cmd_valid_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
            cmd_index_q <= cmd_index_d;
            cmd_arg_q   <= cmd_arg_d;
        end
    end

    assign busy      = (state_q == ST_RX);
    assign cmd_valid = cmd_valid_q;
    assign crc_err   = crc_err_q;
    assign frame_err = frame_err_q;
    assign cmd_index = cmd_index_q;
    assign cmd_arg   = cmd_arg_q;

endmodule

// File: tb/tb_sd_cmd_rx.sv
// tb/tb_sd_cmd_rx.sv - scoreboard testbench for sd_cmd_rx

module tb_sd_cmd_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        sd_clk_i;
    logic        sd_cmd_i;
    logic        rx_enable;
    logic        busy;
    logic        cmd_valid;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        crc_err;
    logic        frame_err;

    sd_cmd_rx #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .sd_clk_i  (sd_clk_i),
        .sd_cmd_i  (sd_cmd_i),
        .rx_enable (rx_enable),
        .busy      (busy),
        .cmd_valid (cmd_valid),
        .cmd_index (cmd_index),
        .cmd_arg   (cmd_arg),
        .crc_err   (crc_err),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // kind = {frame_err, crc_err, cmd_valid}
    typedef struct {
        logic [2:0]  kind;
        logic [5:0]  idx;
        logic [31:0] arg;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [5:0]  exp_idx;
    logic [31:0] exp_arg;

    localparam logic [2:0] K_VALID = 3'b001;
    localparam logic [2:0] K_CRC   = 3'b010;
    localparam logic [2:0] K_FRAME = 3'b100;

    localparam int STOP_NONE  = 0;
    localparam int STOP_RXEN  = 1;
    localparam int STOP_RESET = 2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_valid(input logic [5:0] idx, input logic [31:0] arg);
        exp_t e;
        exp_idx = idx;
        exp_arg = arg;
        e.kind = K_VALID;
        e.idx  = idx;
        e.arg  = arg;
        q.push_back(e);
    endtask

    task automatic push_err(input logic [2:0] kind);
        exp_t e;
        e.kind = kind;
        e.idx  = exp_idx;
        e.arg  = exp_arg;
        q.push_back(e);
    endtask

    // Monitor: pops one expectation per result strobe.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (cmd_valid || crc_err || frame_err)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got %b expected none",
                         {frame_err, crc_err, cmd_valid});
            end else begin
                e = q.pop_front();
                chk("strobe_kind", {61'd0, frame_err, crc_err, cmd_valid}, {61'd0, e.kind});
                chk("index_arg", {26'd0, cmd_index, cmd_arg}, {26'd0, e.idx, e.arg});
            end
        end
    end

    task automatic idle(input int n);
        sd_cmd_i = 1'b1;
        repeat (n) begin
            repeat (4) @(negedge clk);
            sd_clk_i = 1'b1;
            repeat (4) @(negedge clk);
            sd_clk_i = 1'b0;
        end
    endtask

    // Host drives CMD while sd_clk is low; sd_clk is clk/8.
    task automatic send_frame(input logic [47:0] f, input int stop_at, input int stop_kind,
                              input int chk_bit, input logic chk_busy);
        for (int n = 47; n >= 0; n--) begin
            if (n == stop_at && stop_kind == STOP_RXEN) begin
                chk("busy_before_disable", {63'd0, busy}, 64'd1);
                rx_enable = 1'b0;
                @(negedge clk);
                @(negedge clk);
                chk("busy_after_disable", {63'd0, busy}, 64'd0);
                idle(3);
                rx_enable = 1'b1;
                idle(2);
                return;
            end
            if (n == stop_at && stop_kind == STOP_RESET) begin
                reset = 1'b1;
                @(negedge clk);
                @(negedge clk);
                chk("reset_mid_strobes", {60'd0, busy, cmd_valid, crc_err, frame_err}, 64'd0);
                chk("reset_mid_idx_arg", {26'd0, cmd_index, cmd_arg}, 64'd0);
                reset = 1'b0;
                exp_idx = 6'd0;
                exp_arg = 32'd0;
                idle(3);
                return;
            end
            sd_cmd_i = f[n];
            repeat (4) @(negedge clk);
            sd_clk_i = 1'b1;
            repeat (4) @(negedge clk);
            if (n == chk_bit) chk("busy_at_bit", {63'd0, busy}, {63'd0, chk_busy});
            sd_clk_i = 1'b0;
        end
    endtask

    initial begin
        reset     = 1'b1;
        sd_clk_i  = 1'b0;
        sd_cmd_i  = 1'b1;
        rx_enable = 1'b1;
        exp_idx   = 6'd0;
        exp_arg   = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_strobes", {60'd0, busy, cmd_valid, crc_err, frame_err}, 64'd0);
        chk("reset_idx_arg", {26'd0, cmd_index, cmd_arg}, 64'd0);
        reset = 1'b0;
        idle(3);
        chk("idle_high_not_busy", {63'd0, busy}, 64'd0);

        // CMD0
        push_valid(6'd0, 32'd0);
        send_frame(48'h400000000095, -1, STOP_NONE, 47, 1'b1);
        idle(2);

        // CMD8 then CMD55 back to back
        push_valid(6'd8, 32'h000001AA);
        send_frame(48'h48000001AA87, -1, STOP_NONE, -1, 1'b0);
        push_valid(6'd55, 32'd0);
        send_frame(48'h770000000065, -1, STOP_NONE, -1, 1'b0);
        idle(2);

        // CMD8 with corrupted CRC: index/arg hold (55, 0)
        push_err(K_CRC);
        send_frame(48'h48000001AA89, -1, STOP_NONE, -1, 1'b0);
        idle(2);

        // CMD0 with end bit 0
        push_err(K_FRAME);
        send_frame(48'h400000000094, -1, STOP_NONE, -1, 1'b0);
        idle(2);

        // Transmission bit 0: silently dropped after bit 46
        send_frame(48'h080000000001, -1, STOP_NONE, 46, 1'b0);
        idle(2);

        // rx_enable dropped at bit 20, then a full CMD0
        send_frame(48'h48000001AA87, 20, STOP_RXEN, -1, 1'b0);
        push_valid(6'd0, 32'd0);
        send_frame(48'h400000000095, -1, STOP_NONE, -1, 1'b0);
        idle(2);

        // Good CMD8 so the reset check below sees registers return to 0
        push_valid(6'd8, 32'h000001AA);
        send_frame(48'h48000001AA87, -1, STOP_NONE, -1, 1'b0);
        idle(2);
        send_frame(48'h48000001AA87, 30, STOP_RESET, -1, 1'b0);
        push_valid(6'd55, 32'd0);
        send_frame(48'h770000000065, -1, STOP_NONE, -1, 1'b0);
        idle(3);

        repeat (20) @(negedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
